mc_datapath: RTL and testbench
==============================

// Module: mc_datapath
// PURPOSE
//  Multicycle MIPS datapath and state register, directly downstream of the multicycle
//  controller: consumes its control strobes each cycle and returns cs/op to it.
//  Holds PC, IR, MDR, A, B, ALUOut, the 32x32 register file and the ALU.
//  Drives the address and write data of the external unified memory.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC value loaded on reset
//  RESET_STATE  4'd0           cs value loaded on reset (controller fetch state)
// PORTS
//  clk          in   1   single clock; all state updates on rising edge
//  rst          in   1   synchronous, active-high reset
//  ns           in   4   next state from controller
//  cs           out  4   current state register to controller
//  op           out  6   IR[31:26] to controller
//  pcWrite      in   1   unconditional PC load
//  pcWriteCond  in   1   PC load if zero
//  IorD         in   1   mem_addr select: 0 = PC, 1 = ALUOut
//  IRWrite      in   1   load IR from mem_rdata
//  memToReg     in   1   regfile write data: 0 = ALUOut, 1 = MDR
//  pcSource     in   2   00 ALU result, 01 ALUOut, 10 jump target, 11 = hold PC
//  ALUop        in   2   00 add, 01 sub, 10 funct decode, 11 = add
//  ALUsrcB      in   2   00 B, 01 const 4, 10 sext(imm), 11 sext(imm)<<2
//  ALUsrcA      in   1   0 PC, 1 A
//  RegWrite     in   1   regfile write enable
//  RegDst       in   1   write index: 0 = IR[20:16], 1 = IR[15:11]
//  mem_addr     out  32  memory address
//  mem_wdata    out  32  memory write data (= B)
//  mem_rdata    in   32  memory read data; combinational, valid in same cycle
//  pc           out  32  current PC (debug)
//  zero         out  1   ALU result == 0 (combinational)
// BEHAVIOUR
//  - Reset (rst=1 at edge): cs=RESET_STATE, PC=RESET_PC, IR=MDR=A=B=ALUOut=0, all 32 regs=0.
//    Reset mid-instruction aborts it; the next cycle after rst low is fetch at RESET_PC.
//  - Every edge, rst=0: cs<=ns; MDR<=mem_rdata; A<=R[IR[25:21]]; B<=R[IR[20:16]];
//    ALUOut<=ALU result. These registers load unconditionally.
//  - IR<=mem_rdata only when IRWrite=1.
//  - PC loads when pcWrite | (pcWriteCond & zero). Load value selected by pcSource.
//    Jump target = {PC[31:28], IR[25:0], 2'b00}, formed from the PC before the load.
//    pcSource=11 with a load enable leaves PC unchanged.
//  - Regfile write when RegWrite=1.
//    Write index: RegDst mux. Write data: memToReg mux. Writes to index 0 are ignored.
//    R[0] always reads 0.
//    Reads are asynchronous. A read of a register written at the same edge returns the
//    old value (no bypass).
//  - ALU arithmetic: 32-bit, results wrap modulo 2^32, overflow ignored.
//    sext = 16->32 sign extension of IR[15:0].
//    Funct decode (ALUop=10): 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
//    Any other funct = add.
//    slt is signed compare: result 32'd1 / 32'd0.
//  - mem_addr = IorD ? ALUOut : PC (combinational).
//  - Latency per step: one cycle. Each controller state's effects are visible after the
//    edge that ends that state.
//  - No internal handshakes. Memory is assumed zero-wait. memRead/memWrite go from the
//    controller straight to memory.
// TESTING
//  1 Reset: rst=1 for 2 cycles, then 0 -> cs=0, pc=RESET_PC, mem_addr=RESET_PC,
//    R[1..31]=0.
//  2 Fetch: cs=0 strobes (IRWrite, pcWrite, ALUsrcA=0, ALUsrcB=01, pcSource=00),
//    mem_rdata=0x8C22_0004 -> IR=0x8C22_0004, op=6'h23, PC=RESET_PC+4.
//  3 R-type: R1=5, R2=7; run add $3,$1,$2 (0x0022_1820) through fetch/decode/exec/
//    writeback -> R3=12. Repeat with slt, R1=-1, R2=1 -> R3=1.
//  4 beq taken: PC=0x100, imm=3, R1=R2 -> decode ALUOut=0x110; pcWriteCond,
//    pcSource=01 -> PC=0x110. Repeat with R1!=R2 -> PC stays 0x104.
//  5 Jump: PC=0x1000_0004, IR=0x0800_0010, pcWrite, pcSource=10 -> PC=0x1000_0040.
//  6 Writes to $0 ignored: RegWrite with index 0, data 0xFFFF_FFFF -> R0 reads 0.
//    rst asserted in cs=3 -> next cycle cs=0 and PC=RESET_PC.

Source files
------------

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC/IR/MDR/A/B/ALUOut, 32x32 register file and ALU.
// Every state element updates on the rising clock edge; the controller's state register lives here too.
module mc_datapath #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [3:0]  RESET_STATE = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ns,
  output logic [3:0]  cs,
  output logic [5:0]  op,
  input  logic        pcWrite,
  input  logic        pcWriteCond,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic        memToReg,
  input  logic [1:0]  pcSource,
  input  logic [1:0]  ALUop,
  input  logic [1:0]  ALUsrcB,
  input  logic        ALUsrcA,
  input  logic        RegWrite,
  input  logic        RegDst,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic        zero
);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  logic [31:0] pcReg, ir, mdr, aReg, bReg, aluOut;
  logic [31:0] regs [32];

  logic [31:0] sextImm, srcA, srcB, aluResult, pcNext, wData, rdA, rdB;
  logic [4:0]  wIdx;
  logic [2:0]  aluCtl;
  logic        pcLoad;

  assign sextImm = {{16{ir[15]}}, ir[15:0]};
  assign srcA    = ALUsrcA ? aReg : pcReg;

  always_comb begin
    srcB = bReg;
    unique case (ALUsrcB)
      2'b00: srcB = bReg;
      2'b01: srcB = 32'd4;
      2'b10: srcB = sextImm;
      2'b11: srcB = {sextImm[29:0], 2'b00};
    endcase
  end

  // Unlisted functs fall back to add, as does ALUop=11.
  always_comb begin
    aluCtl = ALU_ADD;
    if (ALUop == 2'b01) aluCtl = ALU_SUB;
    else if (ALUop == 2'b10) begin
      unique case (ir[5:0])
        6'h22:   aluCtl = ALU_SUB;
        6'h24:   aluCtl = ALU_AND;
        6'h25:   aluCtl = ALU_OR;
        6'h2A:   aluCtl = ALU_SLT;
        default: aluCtl = ALU_ADD;
      endcase
    end
  end

  always_comb begin
    aluResult = srcA + srcB;
    unique case (aluCtl)
      ALU_SUB: aluResult = srcA - srcB;
      ALU_AND: aluResult = srcA & srcB;
      ALU_OR:  aluResult = srcA | srcB;
      ALU_SLT: aluResult = {31'd0, $signed(srcA) < $signed(srcB)};
      default: aluResult = srcA + srcB;
    endcase
  end

  assign zero = (aluResult == 32'd0);

  // pcSource=11 reloads the current PC, so an enabled load is a no-op.
  always_comb begin
    pcNext = pcReg;
    unique case (pcSource)
      2'b00: pcNext = aluResult;
      2'b01: pcNext = aluOut;
      2'b10: pcNext = {pcReg[31:28], ir[25:0], 2'b00};
      2'b11: pcNext = pcReg;
    endcase
  end

  assign pcLoad = pcWrite | (pcWriteCond & zero);

  assign wIdx  = RegDst ? ir[15:11] : ir[20:16];
  assign wData = memToReg ? mdr : aluOut;
  assign rdA   = (ir[25:21] == 5'd0) ? 32'd0 : regs[ir[25:21]];
  assign rdB   = (ir[20:16] == 5'd0) ? 32'd0 : regs[ir[20:16]];

  always_ff @(posedge clk) begin
    if (rst) begin
      cs     <= RESET_STATE;
      pcReg  <= RESET_PC;
      ir     <= '0;
      mdr    <= '0;
      aReg   <= '0;
      bReg   <= '0;
      aluOut <= '0;
    end else begin
      cs     <= ns;
      mdr    <= mem_rdata;
      aReg   <= rdA;
      bReg   <= rdB;
      aluOut <= aluResult;
      if (IRWrite) ir    <= mem_rdata;
      if (pcLoad)  pcReg <= pcNext;
    end
  end

  // Reads are taken before this edge's write lands: no write-to-read bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (RegWrite && wIdx != 5'd0) begin
      regs[wIdx] <= wData;
    end
  end

  assign op        = ir[31:26];
  assign mem_addr  = IorD ? aluOut : pcReg;
  assign mem_wdata = bReg;
  assign pc        = pcReg;

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: drives controller strobes directly, scoreboard of expected values.
module tb_mc_datapath;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ns, cs;
  logic [5:0]  op;
  logic        pcWrite, pcWriteCond, IorD, IRWrite, memToReg, ALUsrcA, RegWrite, RegDst;
  logic [1:0]  pcSource, ALUop, ALUsrcB;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic        zero;

  always #5 clk = ~clk;

  mc_datapath #(.RESET_PC(RPC), .RESET_STATE(4'd0)) dut (
    .clk(clk), .rst(rst), .ns(ns), .cs(cs), .op(op),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .IorD(IorD), .IRWrite(IRWrite),
    .memToReg(memToReg), .pcSource(pcSource), .ALUop(ALUop), .ALUsrcB(ALUsrcB),
    .ALUsrcA(ALUsrcA), .RegWrite(RegWrite), .RegDst(RegDst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pc(pc), .zero(zero)
  );

  int checks = 0;
  int failures = 0;
  string       sbName[$];
  logic [31:0] sbVal[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  funct;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[9];

  task automatic push(input string n, input logic [31:0] v);
    sbName.push_back(n);
    sbVal.push_back(v);
  endtask

  task automatic pop(input logic [31:0] act);
    string n;
    logic [31:0] v;
    checks++;
    if (sbVal.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty actual=%h", act);
    end else begin
      n = sbName.pop_front();
      v = sbVal.pop_front();
      if (act !== v) begin
        failures++;
        $display("FAIL %s actual=%h expected=%h", n, act, v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pcWrite = 0; pcWriteCond = 0; IorD = 0; IRWrite = 0; memToReg = 0;
    pcSource = 2'b00; ALUop = 2'b00; ALUsrcB = 2'b00; ALUsrcA = 0;
    RegWrite = 0; RegDst = 0;
  endtask

  // R[r] <= v via IR.rt and MDR.
  task automatic writeReg(input logic [4:0] r, input logic [31:0] v);
    idle(); IRWrite = 1; mem_rdata = {6'h23, 5'd0, r, 16'h0}; tick();
    idle(); mem_rdata = v; tick();
    idle(); RegWrite = 1; RegDst = 0; memToReg = 1; tick();
    idle();
  endtask

  // R[r] observed on mem_wdata (B).
  task automatic readReg(input logic [4:0] r, output logic [31:0] v);
    idle(); IRWrite = 1; mem_rdata = {6'h00, 5'd0, r, 16'h0}; tick();
    idle(); tick();
    v = mem_wdata;
  endtask

  // PC <= v through A + R0 on the ALU-result path.
  task automatic setPc(input logic [31:0] v);
    writeReg(5'd30, v);
    idle(); IRWrite = 1; mem_rdata = {6'h00, 5'd30, 5'd0, 16'h0}; tick();
    idle(); tick();
    ALUsrcA = 1; ALUsrcB = 2'b00; pcWrite = 1; pcSource = 2'b00; tick();
    idle();
  endtask

  task automatic fetch(input logic [31:0] instr);
    idle(); mem_rdata = instr; IRWrite = 1; pcWrite = 1; ALUsrcB = 2'b01; ns = 4'd1; tick();
  endtask

  task automatic decode();
    idle(); ALUsrcB = 2'b11; ns = 4'd2; tick();
  endtask

  task automatic runR(input logic [31:0] instr);
    fetch(instr);
    decode();
    idle(); ALUsrcA = 1; ALUop = 2'b10; ns = 4'd6; tick();
    idle(); RegWrite = 1; RegDst = 1; ns = 4'd7; tick();
    idle(); ns = 4'd0;
  endtask

  task automatic beq(input logic [15:0] imm, input logic [31:0] expAluOut,
                     input logic expZero, input logic [31:0] expPc);
    setPc(32'h100);
    push("beq_fetch_addr", 32'h100); #1; pop(mem_addr);
    fetch({6'h04, 5'd1, 5'd2, imm});
    decode();
    idle(); IorD = 1; push("beq_target", expAluOut); #1; pop(mem_addr);
    idle(); ALUsrcA = 1; ALUop = 2'b01; pcWriteCond = 1; pcSource = 2'b01; ns = 4'd0;
    push("beq_zero", {31'd0, expZero}); #1; pop({31'd0, zero});
    tick();
    push("beq_pc", expPc); pop(pc);
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    tbl[0] = '{32'd5,         32'd7,         6'h20, 32'd12};
    tbl[1] = '{32'hFFFF_FFFF, 32'd1,         6'h2A, 32'd1};
    tbl[2] = '{32'd5,         32'd7,         6'h22, 32'hFFFF_FFFE};
    tbl[3] = '{32'hF0F0_1234, 32'hFF00_FF00, 6'h24, 32'hF000_1200};
    tbl[4] = '{32'hF0F0_0000, 32'h0F0F_0001, 6'h25, 32'hFFFF_0001};
    tbl[5] = '{32'd1,         32'hFFFF_FFFF, 6'h2A, 32'd0};
    tbl[6] = '{32'hFFFF_FFFF, 32'd2,         6'h20, 32'd1};
    tbl[7] = '{32'd3,         32'd4,         6'h21, 32'd7};
    tbl[8] = '{32'h7FFF_FFFF, 32'h8000_0000, 6'h2A, 32'd0};

    idle(); rst = 1; ns = 4'd0; mem_rdata = '0;
    tick(); tick();
    rst = 0;
    push("reset_cs", 32'd0);     pop({28'd0, cs});
    push("reset_pc", RPC);       pop(pc);
    push("reset_mem_addr", RPC); pop(mem_addr);

    // Fetch, then decode exposes PC+4 + (sext(4)<<2) on ALUOut.
    fetch(32'h8C22_0004);
    push("fetch_op", 32'h23);    pop({26'd0, op});
    push("fetch_pc", RPC + 4);   pop(pc);
    decode();
    idle(); IorD = 1; push("decode_aluout", RPC + 32'h14); #1; pop(mem_addr);

    for (int i = 0; i < 9; i++) begin
      writeReg(5'd1, tbl[i].a);
      writeReg(5'd2, tbl[i].b);
      push($sformatf("rtype_%0d_f%h", i, tbl[i].funct), tbl[i].exp);
      runR({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, tbl[i].funct});
      readReg(5'd3, v);
      pop(v);
    end

    writeReg(5'd1, 32'd9); writeReg(5'd2, 32'd9);
    beq(16'd3, 32'h110, 1'b1, 32'h110);
    writeReg(5'd1, 32'd3); writeReg(5'd2, 32'd4);
    beq(16'd3, 32'h110, 1'b0, 32'h104);
    writeReg(5'd2, 32'd3);
    beq(16'hFFFE, 32'h0FC, 1'b1, 32'h0FC);

    setPc(32'h1000_0004);
    idle(); IRWrite = 1; mem_rdata = 32'h0800_0010; tick();
    push("jump_op", 32'h02); pop({26'd0, op});
    idle(); pcWrite = 1; pcSource = 2'b10; tick();
    push("jump_pc", 32'h1000_0040); pop(pc);

    setPc(32'h200);
    idle(); pcWrite = 1; pcSource = 2'b11; tick();
    push("hold_pc", 32'h200); pop(pc);

    // srcB=10: sign-extended immediate 0x8000 added to R0.
    idle(); IRWrite = 1; mem_rdata = {6'h08, 5'd0, 5'd0, 16'h8000}; tick();
    idle(); tick();
    ALUsrcA = 1; ALUsrcB = 2'b10; tick();
    idle(); IorD = 1; push("sext_imm", 32'hFFFF_8000); #1; pop(mem_addr);

    writeReg(5'd0, 32'hFFFF_FFFF);
    push("r0_ignored", 32'd0); readReg(5'd0, v); pop(v);

    // B reads the pre-write value of a register written at the same edge.
    writeReg(5'd4, 32'h11);
    idle(); IRWrite = 1; mem_rdata = {6'h23, 5'd0, 5'd4, 16'h0}; tick();
    idle(); mem_rdata = 32'h22; tick();
    idle(); RegWrite = 1; memToReg = 1; tick();
    push("no_bypass_old", 32'h11); pop(mem_wdata);
    idle(); tick();
    push("no_bypass_new", 32'h22); pop(mem_wdata);

    idle(); ns = 4'd3; tick();
    push("mid_cs", 32'd3); pop({28'd0, cs});
    rst = 1; pcWrite = 1; ALUsrcB = 2'b01; ns = 4'd5; tick();
    rst = 0; idle(); ns = 4'd0;
    push("midrst_cs", 32'd0);      pop({28'd0, cs});
    push("midrst_pc", RPC);        pop(pc);
    push("midrst_op", 32'd0);      pop({26'd0, op});
    push("midrst_mem_addr", RPC);  pop(mem_addr);
    for (int r = 1; r < 32; r++) begin
      push($sformatf("reset_r%0d", r), 32'd0);
      readReg(r[4:0], v);
      pop(v);
    end

    if (sbVal.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", sbVal.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
